// File: rtl/timer_pkg.sv
// Shared definitions for the memory-mapped countdown timer: FSM state
// encoding, bus register offsets, mode codes and CTRL bit positions.
package timer_pkg;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      LOAD = 2'd1,
      CNT  = 2'd2,
      INT  = 2'd3
   } state_t;

   // Word offsets within the device window (PrAddr[3:2])
   localparam logic [1:0] CTRL_OFF   = 2'd0;
   localparam logic [1:0] PRESET_OFF = 2'd1;
   localparam logic [1:0] COUNT_OFF  = 2'd2;

   // CTRL.MODE codes; 2'b1x behaves as one-shot
   localparam logic [1:0] MODE_ONESHOT = 2'b00;
   localparam logic [1:0] MODE_RELOAD  = 2'b01;

   // CTRL bit positions
   localparam int CTRL_EN_BIT   = 0;
   localparam int CTRL_MODE_LSB = 1;
   localparam int CTRL_MODE_MSB = 2;
   localparam int CTRL_IM_BIT   = 3;
   localparam int CTRL_W        = 4;

endpackage

// File: rtl/timer_dev.sv
// Countdown timer peripheral. Software programs PRESET and CTRL over the
// decoded bridge bus; the FSM loads PRESET into COUNT, counts down to zero,
// raises irq_pending, and then either stops (one-shot, pending held until
// a CTRL write acknowledges it) or rearms (auto-reload, one-cycle pulse).
// Bus handshake: a write takes effect on the rising edge where Sel and WE
// are both high; there is no back-pressure. Reads are combinational on Addr.
module timer_dev
   import timer_pkg::*;
#(
   parameter int CNT_W = 32
) (
   input  logic        clk,
   input  logic        reset,
   input  logic        Sel,
   input  logic [1:0]  Addr,
   input  logic        WE,
   input  logic [31:0] DIn,
   output logic [31:0] DOut,
   output logic        IRQ
);

   logic [CTRL_W-1:0] ctrl;
   logic [CNT_W-1:0]  preset;
   logic [CNT_W-1:0]  count;
   logic              irq_pending;
   state_t            state;

   logic ctrl_wr;
   logic preset_wr;
   logic reload_mode;

   assign ctrl_wr     = Sel & WE & (Addr == CTRL_OFF);
   assign preset_wr   = Sel & WE & (Addr == PRESET_OFF);
   assign reload_mode = (ctrl[CTRL_MODE_MSB:CTRL_MODE_LSB] == MODE_RELOAD);

   // Register file and countdown FSM share one block: the FSM writes CTRL.EN
   // and irq_pending, which the bus also writes, so priority is set by order.
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         ctrl        <= '0;
         preset      <= '0;
         count       <= '0;
         irq_pending <= 1'b0;
         state       <= IDLE;
      end else begin
         if (preset_wr) begin
            preset <= DIn[CNT_W-1:0];
         end

         // Software acknowledge; placed before the FSM so an expiry in the
         // same cycle overrides it and no interrupt is lost.
         if (ctrl_wr) begin
            irq_pending <= 1'b0;
         end

         case (state)
            IDLE: begin
               if (ctrl[CTRL_EN_BIT]) begin
                  state <= LOAD;
               end
            end
            LOAD: begin
               count <= preset;
               state <= CNT;
            end
            CNT: begin
               if (!ctrl[CTRL_EN_BIT]) begin
                  state <= IDLE;
               end else if (count <= CNT_W'(1)) begin
                  // PRESET=0 lands here too, so COUNT never wraps
                  count       <= '0;
                  irq_pending <= 1'b1;
                  state       <= INT;
               end else begin
                  count <= count - CNT_W'(1);
               end
            end
            INT: begin
               if (reload_mode) begin
                  irq_pending <= 1'b0;
               end else begin
                  ctrl[CTRL_EN_BIT] <= 1'b0;
               end
               state <= IDLE;
            end
            default: begin
               state <= IDLE;
            end
         endcase

         // Bus write to CTRL after the FSM so the software value wins
         if (ctrl_wr) begin
            ctrl <= DIn[CTRL_W-1:0];
         end
      end
   end

   // Read mux; narrow registers are zero-extended, reserved offset reads 0
   always_comb begin
      DOut = '0;
      case (Addr)
         CTRL_OFF:   DOut[CTRL_W-1:0] = ctrl;
         PRESET_OFF: DOut[CNT_W-1:0]  = preset;
         COUNT_OFF:  DOut[CNT_W-1:0]  = count;
         default:    DOut = '0;
      endcase
   end

   assign IRQ = ctrl[CTRL_IM_BIT] & irq_pending;

endmodule

// File: tb/tb_timer_dev.sv
// Self-checking bench for timer_dev: register-access vector table, directed
// multi-cycle sequences, and randomized timer runs compared against a
// closed-form timing model.
module tb_timer_dev;
   import timer_pkg::*;

   logic        clk   = 1'b0;
   logic        reset = 1'b0;
   logic        Sel   = 1'b0;
   logic        WE    = 1'b0;
   logic [1:0]  Addr  = 2'd0;
   logic [31:0] DIn   = 32'd0;
   logic [31:0] DOut;
   logic        IRQ;

   int checks   = 0;
   int failures = 0;

   timer_dev #(.CNT_W(32)) dut (
      .clk   (clk),
      .reset (reset),
      .Sel   (Sel),
      .Addr  (Addr),
      .WE    (WE),
      .DIn   (DIn),
      .DOut  (DOut),
      .IRQ   (IRQ)
   );

   // Clock
   always #5 clk = ~clk;

   typedef struct {
      logic        sel;
      logic        we;
      logic [1:0]  addr;
      logic [31:0] din;
      logic [1:0]  rd_addr;
      logic [31:0] exp_dout;
   } vec_t;

   vec_t vecs[8];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s actual=0x%0h expected=0x%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic bus_write(input logic [1:0] a, input logic [31:0] d);
      Sel  = 1'b1;
      WE   = 1'b1;
      Addr = a;
      DIn  = d;
      step();
      Sel  = 1'b0;
      WE   = 1'b0;
   endtask

   task automatic bus_read(input logic [1:0] a, output logic [31:0] d);
      Addr = a;
      #1;
      d = DOut;
   endtask

   task automatic do_reset();
      Sel   = 1'b0;
      WE    = 1'b0;
      reset = 1'b0;
      step();
      step();
      @(negedge clk);
      reset = 1'b1;
      step();
   endtask

   // Timing model. t = edges since the edge that wrote EN=1, COUNT was 0 before.
   // Each run: LOAD edge, then M=max(N,1) counting edges ending in expiry,
   // then INT and IDLE edges before the next LOAD (period M+3).
   function automatic logic [31:0] model_count(int n, bit reload, int t);
      int m;
      int o;
      m = (n < 1) ? 1 : n;
      if (t < 2) return 32'd0;
      o = t - 2;
      if (reload) o = o % (m + 3);
      return (o < m) ? 32'(n - o) : 32'd0;
   endfunction

   function automatic logic model_pending(int n, bit reload, int t);
      int m;
      m = (n < 1) ? 1 : n;
      if (t < 2) return 1'b0;
      if (reload) return ((t - 2) % (m + 3)) == m;
      return (t - 2) >= m;
   endfunction

   initial begin
      logic [31:0] d;
      logic [31:0] seq6 [9];
      bit          found;

      // ---------------- reset state ----------------
      reset = 1'b0;
      step();
      bus_read(CTRL_OFF, d);   check("rst_ctrl", d, 32'd0);
      bus_read(PRESET_OFF, d); check("rst_preset", d, 32'd0);
      bus_read(COUNT_OFF, d);  check("rst_count", d, 32'd0);
      check("rst_irq", {31'd0, IRQ}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // ---------------- register access table ----------------
      vecs[0] = '{1'b1, 1'b1, CTRL_OFF,   32'hFFFF_FFF6, CTRL_OFF,   32'h6};
      vecs[1] = '{1'b1, 1'b1, PRESET_OFF, 32'h1234_5678, PRESET_OFF, 32'h1234_5678};
      vecs[2] = '{1'b1, 1'b1, COUNT_OFF,  32'h0000_005A, COUNT_OFF,  32'h0};
      vecs[3] = '{1'b1, 1'b1, 2'd3,       32'hFFFF_FFFF, 2'd3,       32'h0};
      vecs[4] = '{1'b0, 1'b1, PRESET_OFF, 32'h0000_DEAD, PRESET_OFF, 32'h1234_5678};
      vecs[5] = '{1'b1, 1'b0, CTRL_OFF,   32'h0000_000F, CTRL_OFF,   32'h6};
      vecs[6] = '{1'b0, 1'b1, CTRL_OFF,   32'h0000_0001, CTRL_OFF,   32'h6};
      vecs[7] = '{1'b1, 1'b1, CTRL_OFF,   32'h0000_0000, CTRL_OFF,   32'h0};
      for (int i = 0; i < 8; i++) begin
         Sel  = vecs[i].sel;
         WE   = vecs[i].we;
         Addr = vecs[i].addr;
         DIn  = vecs[i].din;
         step();
         Sel = 1'b0;
         WE  = 1'b0;
         bus_read(vecs[i].rd_addr, d);
         check($sformatf("vec%0d_dout", i), d, vecs[i].exp_dout);
      end
      bus_read(COUNT_OFF, d);
      check("vec_count_idle", d, 32'd0);

      // ---------------- reset mid-count ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd10);
      bus_write(CTRL_OFF, 32'h9);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         bus_read(COUNT_OFF, d);
         if (d == 32'd5) found = 1'b1;
      end
      check("midrst_reach5", {31'd0, found}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      bus_read(COUNT_OFF, d);  check("midrst_count", d, 32'd0);
      bus_read(CTRL_OFF, d);   check("midrst_ctrl", d, 32'd0);
      check("midrst_irq", {31'd0, IRQ}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // ---------------- one-shot PRESET=3 ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd3);
      bus_write(CTRL_OFF, 32'h9);
      for (int t = 1; t <= 5; t++) begin
         step();
         check($sformatf("os_irq_t%0d", t), {31'd0, IRQ}, (t == 5) ? 32'd1 : 32'd0);
      end
      step();
      step();
      check("os_irq_held", {31'd0, IRQ}, 32'd1);
      bus_read(CTRL_OFF, d);  check("os_ctrl", d, 32'h8);
      bus_read(COUNT_OFF, d); check("os_count", d, 32'd0);
      bus_write(CTRL_OFF, 32'h8);
      check("os_ack_irq", {31'd0, IRQ}, 32'd0);
      bus_write(CTRL_OFF, 32'h9);
      for (int t = 1; t <= 5; t++) step();
      check("os_rearm_irq", {31'd0, IRQ}, 32'd1);
      #2;
      reset = 1'b0;
      #1;
      check("os_rst_irq_drop", {31'd0, IRQ}, 32'd0);
      @(negedge clk);
      reset = 1'b1;
      step();

      // ---------------- auto-reload PRESET=2, 4 periods ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd2);
      bus_write(CTRL_OFF, 32'hB);
      for (int t = 1; t <= 22; t++) begin
         step();
         check($sformatf("ar_irq_t%0d", t), {31'd0, IRQ}, {31'd0, model_pending(2, 1'b1, t)});
         bus_read(COUNT_OFF, d);
         check($sformatf("ar_count_t%0d", t), d, model_count(2, 1'b1, t));
      end

      // ---------------- pause and re-enable ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd10);
      bus_write(CTRL_OFF, 32'h1);
      found = 1'b0;
      for (int i = 0; i < 30 && !found; i++) begin
         step();
         bus_read(COUNT_OFF, d);
         if (d == 32'd8) found = 1'b1;
      end
      check("pause_reach8", {31'd0, found}, 32'd1);
      bus_write(CTRL_OFF, 32'h0);
      for (int i = 0; i < 3; i++) begin
         step();
         bus_read(COUNT_OFF, d);
         check($sformatf("pause_hold%0d", i), d, 32'd7);
      end
      bus_write(PRESET_OFF, 32'd4);
      bus_write(CTRL_OFF, 32'h1);
      step();
      bus_read(COUNT_OFF, d); check("pause_load_edge", d, 32'd7);
      step();
      bus_read(COUNT_OFF, d); check("pause_reload", d, 32'd4);

      // ---------------- masked interrupt ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd1);
      bus_write(CTRL_OFF, 32'h1);
      for (int t = 1; t <= 4; t++) begin
         step();
         check($sformatf("mask_irq_t%0d", t), {31'd0, IRQ}, 32'd0);
         if (t >= 3) check($sformatf("mask_pend_t%0d", t), {31'd0, dut.irq_pending}, 32'd1);
      end
      bus_read(CTRL_OFF, d); check("mask_ctrl_en_clr", d, 32'h0);
      bus_write(CTRL_OFF, 32'h8);
      check("mask_ack_pend", {31'd0, dut.irq_pending}, 32'd0);
      check("mask_ack_irq", {31'd0, IRQ}, 32'd0);

      // ---------------- expiry and CTRL write in the same cycle ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd1);
      bus_write(CTRL_OFF, 32'h1);
      step();
      step();
      bus_write(CTRL_OFF, 32'h9);
      check("setwins_irq", {31'd0, IRQ}, 32'd1);
      step();
      check("setwins_irq_held", {31'd0, IRQ}, 32'd1);
      bus_read(CTRL_OFF, d); check("setwins_ctrl", d, 32'h8);

      // ---------------- CTRL write during INT ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd2);
      bus_write(CTRL_OFF, 32'h9);
      for (int t = 1; t <= 4; t++) step();
      check("intwr_irq_before", {31'd0, IRQ}, 32'd1);
      bus_write(CTRL_OFF, 32'h9);
      bus_read(CTRL_OFF, d); check("intwr_ctrl_bus_wins", d, 32'h9);
      check("intwr_irq_acked", {31'd0, IRQ}, 32'd0);
      for (int t = 1; t <= 4; t++) begin
         step();
         check($sformatf("intwr_restart_t%0d", t), {31'd0, IRQ}, (t == 4) ? 32'd1 : 32'd0);
      end

      // ---------------- PRESET write mid-count ----------------
      do_reset();
      bus_write(PRESET_OFF, 32'd6);
      bus_write(CTRL_OFF, 32'h3);
      step();
      step();
      bus_read(COUNT_OFF, d); check("pmid_loaded", d, 32'd6);
      seq6 = '{32'd5, 32'd4, 32'd3, 32'd2, 32'd1, 32'd0, 32'd0, 32'd0, 32'd2};
      bus_write(PRESET_OFF, 32'd2);
      for (int i = 0; i < 9; i++) begin
         if (i > 0) step();
         bus_read(COUNT_OFF, d);
         check($sformatf("pmid_count%0d", i), d, seq6[i]);
      end

      // ---------------- randomized runs ----------------
      for (int trial = 0; trial < 10; trial++) begin
         int          n;
         int          mode;
         int          im;
         int          len;
         bit          reload;
         logic        exp_irq;
         n      = int'($urandom_range(0, 6));
         mode   = int'($urandom_range(0, 3));
         im     = int'($urandom_range(0, 1));
         reload = (2'(mode) == MODE_RELOAD);
         len    = 3 * (((n < 1) ? 1 : n) + 3) + 1;
         do_reset();
         bus_write(PRESET_OFF, 32'(n));
         bus_write(CTRL_OFF, 32'(im * 8 + mode * 2 + 1));
         for (int t = 1; t <= len; t++) begin
            step();
            exp_irq = model_pending(n, reload, t) & (im == 1);
            check($sformatf("rnd%0d_n%0d_m%0d_irq_t%0d", trial, n, mode, t), {31'd0, IRQ}, {31'd0, exp_irq});
            bus_read(COUNT_OFF, d);
            check($sformatf("rnd%0d_n%0d_m%0d_cnt_t%0d", trial, n, mode, t), d, model_count(n, reload, t));
         end
      end

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
